// File: rtl/servo_cmd_pkg.sv
// ============================================================================
// Module      : servo_cmd_pkg
// Description : Shared constants, FSM state type and checksum helper for the
//               servo command parser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package servo_cmd_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hFF;
    localparam int         POS_W    = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_HDR = 2'd1,
        GOT_X   = 2'd2,
        GOT_Y   = 2'd3
    } state_t;

    // Frame checksum: 8-bit sum of X and Y, folded to 7 bits so the
    // checksum byte can never be mistaken for a header or bad byte.
    function automatic logic [7:0] calc_chk(input logic [POS_W-1:0] x,
                                            input logic [POS_W-1:0] y);
        logic [7:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        return {1'b0, sum[6:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/servo_cmd_if.sv
// ============================================================================
// Module      : servo_cmd_if
// Description : Byte-stream input and position output bundle of the servo
//               command parser.
//                 rx_data/rx_valid     : byte strobe from the UART receiver
//                 pos_x/pos_y          : committed servo positions
//                 pos_update/frame_err : one-cycle status pulses
//               master = byte source / position consumer, slave = parser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface servo_cmd_if;
    import servo_cmd_pkg::*;

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic             pos_update;
    logic             frame_err;

    modport master (
        output rx_data, rx_valid,
        input  pos_x, pos_y, pos_update, frame_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output pos_x, pos_y, pos_update, frame_err
    );

endinterface

`default_nettype wire

// File: rtl/servo_cmd_parser_frame_timer.sv
// ============================================================================
// Module      : frame_timer
// Description : Inter-byte gap counter. Clears on clr, counts while en is
//               high, and flags timeout during the cycle in which the count
//               sits at TIMEOUT_CYCLES-1.
//                 clk, rst : clock and synchronous active-high reset
//                 clr      : clear the count (takes priority over en)
//                 en       : count enable
//                 timeout  : high while enabled count equals TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      timeout
);

    localparam int                CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at the terminal value so a stalled owner cannot wrap it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != C_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = en && (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/servo_cmd_parser.sv
// ============================================================================
// Module      : servo_cmd_parser
// Description : Assembles framed servo commands from a UART byte stream and
//               atomically updates the X/Y position registers on a valid
//               frame. Bad bytes, checksum errors and inter-byte timeouts
//               pulse frame_err and leave the positions untouched.
//                 clk, rst : clock and synchronous active-high reset
//                 bus      : servo_cmd_if.slave (byte input, positions out)
//               Build option SERVO_CMD_CHECKSUM_EN: when defined, frames are
//               HDR,X,Y,CHK; otherwise HDR,X,Y with commit on the Y byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_cmd_parser
    import servo_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int POS_RESET      = 64
) (
    input  wire logic  clk,
    input  wire logic  rst,
    servo_cmd_if.slave bus
);

    state_t           state_q, state_d;
    logic [POS_W-1:0] x_q, x_d;
`ifdef SERVO_CMD_CHECKSUM_EN
    logic [POS_W-1:0] y_q, y_d;
`endif
    logic [POS_W-1:0] pos_x_q, pos_x_d;
    logic [POS_W-1:0] pos_y_q, pos_y_d;
    logic             pos_update_q, pos_update_d;
    logic             frame_err_q, frame_err_d;

    logic             w_timer_clr;
    logic             w_timer_en;
    logic             w_timeout;

    assign w_timer_clr = bus.rx_valid || (state_q == IDLE);
    assign w_timer_en  = (state_q != IDLE);

    frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_timer_clr),
        .en      (w_timer_en),
        .timeout (w_timeout)
    );

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
`ifdef SERVO_CMD_CHECKSUM_EN
        y_d          = y_q;
`endif
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        pos_update_d = 1'b0;
        frame_err_d  = 1'b0;

        // A received byte always wins over a timeout in the same cycle.
        if (bus.rx_valid) begin
            if (state_q == IDLE) begin
                // Noise between frames is dropped without complaint.
                if (bus.rx_data == HDR_BYTE) begin
                    state_d = GOT_HDR;
                end
            end else if (bus.rx_data == HDR_BYTE) begin
                // Header mid-frame: report the broken frame, start a new one.
                frame_err_d = 1'b1;
                state_d     = GOT_HDR;
            end else if (bus.rx_data[7]) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
            end else begin
                case (state_q)
                    GOT_HDR: begin
                        x_d     = bus.rx_data[POS_W-1:0];
                        state_d = GOT_X;
                    end
                    GOT_X: begin
`ifdef SERVO_CMD_CHECKSUM_EN
                        y_d     = bus.rx_data[POS_W-1:0];
                        state_d = GOT_Y;
`else
                        pos_x_d      = x_q;
                        pos_y_d      = bus.rx_data[POS_W-1:0];
                        pos_update_d = 1'b1;
                        state_d      = IDLE;
`endif
                    end
`ifdef SERVO_CMD_CHECKSUM_EN
                    GOT_Y: begin
                        if (bus.rx_data == calc_chk(x_q, y_q)) begin
                            pos_x_d      = x_q;
                            pos_y_d      = y_q;
                            pos_update_d = 1'b1;
                        end else begin
                            frame_err_d  = 1'b1;
                        end
                        state_d = IDLE;
                    end
`endif
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else if (w_timeout) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
`ifdef SERVO_CMD_CHECKSUM_EN
            y_q          <= '0;
`endif
            pos_x_q      <= POS_W'(POS_RESET);
            pos_y_q      <= POS_W'(POS_RESET);
            pos_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
`ifdef SERVO_CMD_CHECKSUM_EN
            y_q          <= y_d;
`endif
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            pos_update_q <= pos_update_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.pos_x      = pos_x_q;
    assign bus.pos_y      = pos_y_q;
    assign bus.pos_update = pos_update_q;
    assign bus.frame_err  = frame_err_q;

endmodule

`default_nettype wire
